// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: RV32 opcodes, the NOP filler encoding
// and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_ENC = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OPIMM};

  typedef enum logic {
    FETCH    = 1'b0,
    BUFFERED = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holder for a fetched word (instr + pc) that arrived while IF/ID was stalled.
module fetch_skid_buffer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (i_clear) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = 1'b1;
      instr_d = i_instr;
      pc_d    = i_pc;
    end else if (i_drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register feeding data_hazard_unit.
// Optional STALL_COUNTER_EN adds a saturating bubble-cycle counter on o_stall_cycles.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic        o_if_id_valid,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_bubble
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0] o_stall_cycles
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         drop_q, drop_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         ack;
  logic [31:0]  redir_pc;

  assign ack      = req_q & i_imem_ack;
  assign redir_pc = word_align(i_redirect_pc);

  fetch_skid_buffer u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clear (skid_clear),
    .i_instr (i_imem_data),
    .i_pc    (pc_q),
    .o_valid (skid_valid),
    .o_instr (skid_instr),
    .o_pc    (skid_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (i_redirect) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      pc_d       = redir_pc;
      state_d    = FETCH;
      req_d      = 1'b1;
      // An unacked request must complete at its original address; its data is dropped.
      if (req_q && !i_imem_ack) begin
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b0;
        addr_d = redir_pc;
      end
    end else if (state_q == FETCH) begin
      req_d = 1'b1;
      if (!req_q) addr_d = pc_q;
      if (ack && drop_q) begin
        drop_d = 1'b0;
        addr_d = pc_q;
      end else if (ack && i_stall) begin
        skid_load = 1'b1;
        pc_d      = pc_q + 32'd4;
        addr_d    = pc_q + 32'd4;
        req_d     = 1'b0;
        state_d   = BUFFERED;
      end else if (ack) begin
        instr_d = i_imem_data;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
        addr_d  = pc_q + 32'd4;
      end
      // ID consumed the slot and nothing new arrived: leave an empty slot, not a repeat.
      if (!i_stall && !(ack && !drop_q)) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else if (!i_stall) begin
      instr_d    = skid_instr;
      ifpc_d     = skid_pc;
      valid_d    = skid_valid;
      skid_drain = 1'b1;
      state_d    = FETCH;
      req_d      = 1'b1;
      addr_d     = pc_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = addr_q;
  assign o_if_id_instr = instr_q;
  assign o_if_id_pc    = ifpc_q;
  assign o_if_id_valid = valid_q;
  assign o_opcode      = instr_q[6:0];
  assign o_rs1         = instr_q[19:15];
  assign o_rs2         = instr_q[24:20];
  assign o_bubble      = i_stall & valid_q & ~i_rst;

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_bubble && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: acked words are queued and matched as they land in IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        i_rst, i_imem_ack, i_stall, i_redirect;
  logic [31:0] i_imem_data, i_redirect_pc;
  logic        o_imem_req, o_if_id_valid, o_bubble;
  logic [31:0] o_imem_addr, o_if_id_instr, o_if_id_pc;
  logic [6:0]  o_opcode;
  logic [4:0]  o_rs1, o_rs2;
`ifdef STALL_COUNTER_EN
  logic [31:0] o_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h100), .NOP_INSTR(32'h13)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_if_id_instr(o_if_id_instr), .o_if_id_pc(o_if_id_pc), .o_if_id_valid(o_if_id_valid),
    .o_opcode(o_opcode), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_bubble(o_bubble)
`ifdef STALL_COUNTER_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  logic        last_bubble;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h108) return 32'h0020_81B3;  // ADD x3,x1,x2
    return {a[13:7], a[6:2], ~a[6:2], 3'b000, a[11:7], 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply inputs for the coming edge, sample the combinational bubble, advance a cycle.
  task automatic cyc(input bit ack, input bit stall, input bit redir,
                     input logic [31:0] rpc, input bit keep);
    i_imem_ack    = ack & o_imem_req;
    i_imem_data   = mem_word(o_imem_addr);
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    if (ack && o_imem_req && keep) exp_q.push_back({o_imem_addr, mem_word(o_imem_addr)});
    #1 last_bubble = o_bubble;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (o_if_id_valid && (!prev_valid || o_if_id_pc != prev_pc)) begin
      chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("sb_ifid", {o_if_id_pc, o_if_id_instr}, exp_q.pop_front());
    end
    prev_valid = o_if_id_valid;
    prev_pc    = o_if_id_pc;
  end

  initial begin
    #100000;
    $display("FAIL timeout: no finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset, with stall held high to show the bubble stays low
    i_rst = 1'b1;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("rst_req",    64'(o_imem_req), 64'd0);
    chk("rst_valid",  64'(o_if_id_valid), 64'd0);
    chk("rst_instr",  64'(o_if_id_instr), 64'h13);
    chk("rst_ifpc",   64'(o_if_id_pc), 64'd0);
    chk("rst_bubble", 64'(last_bubble), 64'd0);

    // Streaming fetch from RESET_PC
    i_rst = 1'b0;
    for (int k = 0; k < 4 && !o_imem_req; k++) cyc(0, 0, 0, 0, 0);
    chk("req_after_rst", 64'(o_imem_req), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stream_addr", 64'(o_imem_addr), 64'(32'h100 + 32'(4 * i)));
      cyc(1, 0, 0, 0, 1);
      chk("stream_bubble", 64'(last_bubble), 64'd0);
    end
    chk("stream_ifpc", 64'(o_if_id_pc), 64'h108);
    chk("stream_next", 64'(o_imem_addr), 64'h10C);
    chk("dec_opcode",  64'(o_opcode), 64'h33);
    chk("dec_rs1",     64'(o_rs1), 64'd1);
    chk("dec_rs2",     64'(o_rs2), 64'd2);

    // Stall two cycles while the next word is acked into the skid buffer
    cyc(1, 1, 0, 0, 1);
    chk("stall1_bubble", 64'(last_bubble), 64'd1);
    chk("stall1_ifpc",   64'(o_if_id_pc), 64'h108);
    chk("stall1_req",    64'(o_imem_req), 64'd0);
    cyc(0, 1, 0, 0, 0);
    chk("stall2_bubble", 64'(last_bubble), 64'd1);
    chk("stall2_ifpc",   64'(o_if_id_pc), 64'h108);
    cyc(0, 0, 0, 0, 0);
    chk("release_bubble", 64'(last_bubble), 64'd0);
    chk("release_ifpc",   64'(o_if_id_pc), 64'h10C);
    chk("release_req",    64'(o_imem_req), 64'd1);
    chk("release_addr",   64'(o_imem_addr), 64'h110);

    // Redirect coinciding with ack; low target bits ignored
    cyc(1, 0, 1, 32'h203, 0);
    chk("redir_ack_addr",  64'(o_imem_addr), 64'h200);
    chk("redir_ack_valid", 64'(o_if_id_valid), 64'd0);
    chk("redir_ack_instr", 64'(o_if_id_instr), 64'h13);
    chk("nop_opcode",      64'(o_opcode), 64'h13);
    chk("nop_rs1",         64'(o_rs1), 64'd0);

    // Redirect with the 0x200 request outstanding; ack three cycles later is dropped
    cyc(0, 0, 1, 32'h400, 0);
    chk("drop_addr0", 64'(o_imem_addr), 64'h200);
    chk("drop_req",   64'(o_imem_req), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("drop_addr1", 64'(o_imem_addr), 64'h200);
    cyc(0, 0, 0, 0, 0);
    chk("drop_addr2", 64'(o_imem_addr), 64'h200);
    cyc(1, 0, 0, 0, 0);
    chk("drop_target", 64'(o_imem_addr), 64'h400);
    chk("drop_valid",  64'(o_if_id_valid), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("target_valid", 64'(o_if_id_valid), 64'd1);
    chk("target_next",  64'(o_imem_addr), 64'h404);

    // Ack and redirect to 0x80 together, then PC wrap at the top of memory
    cyc(1, 0, 1, 32'h80, 0);
    chk("redir80_addr",  64'(o_imem_addr), 64'h80);
    chk("redir80_valid", 64'(o_if_id_valid), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("redir80_next", 64'(o_imem_addr), 64'h84);
    cyc(1, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_addr", 64'(o_imem_addr), 64'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1);
    chk("wrap_zero", 64'(o_imem_addr), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("wrap_ifpc", 64'(o_if_id_pc), 64'd0);
    chk("wrap_four", 64'(o_imem_addr), 64'd4);

`ifdef STALL_COUNTER_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("cnt_sat", 64'(o_stall_cycles), 64'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0);
`endif

    // Reset while a word sits in the skid buffer
    cyc(1, 1, 0, 0, 0);
    chk("buf_req", 64'(o_imem_req), 64'd0);
    i_rst = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("midrst_bubble", 64'(last_bubble), 64'd0);
    chk("midrst_valid",  64'(o_if_id_valid), 64'd0);
    chk("midrst_instr",  64'(o_if_id_instr), 64'h13);
    chk("midrst_req",    64'(o_imem_req), 64'd0);
    i_rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("postrst_valid", 64'(o_if_id_valid), 64'd0);
    chk("postrst_req",   64'(o_imem_req), 64'd1);
    chk("postrst_addr",  64'(o_imem_addr), 64'h100);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
